fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fb_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out fetch beats clear-fill beats the writer,
// with exactly one RAM access per vga_clk cycle.
//
// state   | meaning
// --------|--------------------------------------------------------------
// ST_IDLE | no clear running; writer may be granted on free cycles
// ST_CLEAR| filling every cell with the latched colour on free cycles
module fb_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE      = 2,
  parameter int ADDR_W     = 15,
  parameter int STARVE_LIM = 255
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              pix_req,
  input  logic [9:0]        pix_col,
  input  logic [9:0]        pix_row,
  output logic [8:0]        pix_data,
  output logic              pix_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [8:0]        wr_data,
  output logic              wr_ack,
  output logic              wr_starve,
  input  logic              clr_start,
  input  logic [8:0]        clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [8:0]        mem_wdata,
  output logic              mem_we,
  input  logic [8:0]        mem_rdata
);

  localparam int WAIT_W = ($clog2(STARVE_LIM + 1) < 8) ? 8 : $clog2(STARVE_LIM + 1);
  localparam logic [ADDR_W:0]   CELLS     = (ADDR_W + 1)'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [WAIT_W-1:0] LIM       = WAIT_W'(STARVE_LIM);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [8:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [8:0]          pix_data_q, pix_data_d;
  logic                pix_valid_q, pix_valid_d;
  logic                rd_p1_q, rd_p1_d;
  logic                rd_p2_q, rd_p2_d;
  logic                wr_ack_q, wr_ack_d;
  logic                wr_starve_q, wr_starve_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                clr_busy_q, clr_busy_d;
  logic                clr_done_q, clr_done_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [8:0]          clr_color_q, clr_color_d;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                grant;

  assign fetch_addr = ADDR_W'(pix_row >> SCALE) * ADDR_W'(FB_W) + ADDR_W'(pix_col >> SCALE);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    clr_done_d  = 1'b0;
    clr_busy_d  = clr_busy_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    grant       = 1'b0;
    // Two-stage request pipe matches the RAM's one-cycle read latency plus our capture flop.
    rd_p1_d     = pix_req;
    rd_p2_d     = rd_p1_q;
    pix_valid_d = rd_p2_q;
    pix_data_d  = rd_p2_q ? mem_rdata : pix_data_q;

    if (pix_req) begin
      mem_addr_d = fetch_addr;
    end

    if (state_q == ST_IDLE) begin
      if (clr_start) begin
        state_d     = ST_CLEAR;
        clr_cnt_d   = '0;
        clr_color_d = clr_color;
        clr_busy_d  = 1'b1;
      end else if (!pix_req && wr_req) begin
        grant    = 1'b1;
        wr_ack_d = 1'b1;
        // Out-of-range writes are acknowledged but dropped so the writer never stalls.
        if ({1'b0, wr_addr} < CELLS) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr;
          mem_wdata_d = wr_data;
        end
      end
    end else if (!pix_req) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = clr_cnt_q;
      mem_wdata_d = clr_color_q;
      if (clr_cnt_q == LAST_CELL) begin
        state_d    = ST_IDLE;
        clr_busy_d = 1'b0;
        clr_done_d = 1'b1;
        clr_cnt_d  = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
    end

    if (!wr_req || grant) begin
      wait_d = '0;
    end else if (wait_q != {WAIT_W{1'b1}}) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
    wr_starve_d = (wait_d >= LIM);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_starve_q <= 1'b0;
      wait_q      <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      wr_ack_q    <= wr_ack_d;
      wr_starve_q <= wr_starve_d;
      wait_q      <= wait_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign wr_ack    = wr_ack_q;
  assign wr_starve = wr_starve_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port RAM (one-cycle read latency).
module tb_fb_arbiter;

  logic        vga_clk;
  logic        reset_n;
  logic        pix_req;
  logic [9:0]  pix_col;
  logic [9:0]  pix_row;
  logic [8:0]  pix_data;
  logic        pix_valid;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [8:0]  wr_data;
  logic        wr_ack;
  logic        wr_starve;
  logic        clr_start;
  logic [8:0]  clr_color;
  logic        clr_busy;
  logic        clr_done;
  logic [14:0] mem_addr;
  logic [8:0]  mem_wdata;
  logic        mem_we;
  logic [8:0]  mem_rdata;

  logic [8:0]  ram [0:32767];

  int checks   = 0;
  int failures = 0;

  fb_arbiter dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .pix_req   (pix_req),
    .pix_col   (pix_col),
    .pix_row   (pix_row),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .wr_starve (wr_starve),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_pix_data"},  32'(pix_data),  32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_wr_ack"},    32'(wr_ack),    32'd0);
    chk({tag, "_wr_starve"}, 32'(wr_starve), 32'd0);
    chk({tag, "_clr_busy"},  32'(clr_busy),  32'd0);
    chk({tag, "_clr_done"},  32'(clr_done),  32'd0);
  endtask

  initial begin
    int  cnt;
    bit  done_seen;
    bit  found;

    reset_n   = 1'b0;
    pix_req   = 1'b0;
    pix_col   = '0;
    pix_row   = '0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clr_start = 1'b0;
    clr_color = '0;
    tick;
    tick;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    tick;

    // Preload two cells through the writer port
    wr_req = 1'b1; wr_addr = 15'd322; wr_data = 9'h1C0;
    tick;
    chk("wr322_ack",   32'(wr_ack),    32'd1);
    chk("wr322_we",    32'(mem_we),    32'd1);
    chk("wr322_addr",  32'(mem_addr),  32'd322);
    chk("wr322_data",  32'(mem_wdata), 32'h1C0);
    wr_addr = 15'd321; wr_data = 9'h0AA;
    tick;
    chk("wr321_ack",   32'(wr_ack),    32'd1);
    chk("wr321_addr",  32'(mem_addr),  32'd321);
    wr_req = 1'b0;
    tick;
    chk("idle_ack",    32'(wr_ack),    32'd0);
    chk("idle_we",     32'(mem_we),    32'd0);
    chk("idle_addr",   32'(mem_addr),  32'd321);

    // Back-to-back scan-out: (9>>2)*160+(5>>2)=321, (9>>2)*160+(8>>2)=322
    pix_req = 1'b1; pix_col = 10'd5; pix_row = 10'd9;
    tick;
    chk("so1_addr",    32'(mem_addr),  32'd321);
    chk("so1_we",      32'(mem_we),    32'd0);
    chk("so1_valid",   32'(pix_valid), 32'd0);
    pix_col = 10'd8;
    tick;
    chk("so2_addr",    32'(mem_addr),  32'd322);
    chk("so2_valid",   32'(pix_valid), 32'd0);
    pix_req = 1'b0;
    tick;
    chk("so3_valid",   32'(pix_valid), 32'd1);
    chk("so3_data",    32'(pix_data),  32'h0AA);
    chk("so3_addr",    32'(mem_addr),  32'd322);
    tick;
    chk("so4_valid",   32'(pix_valid), 32'd1);
    chk("so4_data",    32'(pix_data),  32'h1C0);
    tick;
    chk("so5_valid",   32'(pix_valid), 32'd0);
    chk("so5_hold",    32'(pix_data),  32'h1C0);

    // Out-of-range write is acked but discarded
    wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 9'h1FF;
    tick;
    chk("oor_ack",     32'(wr_ack),    32'd1);
    chk("oor_we",      32'(mem_we),    32'd0);
    wr_req = 1'b0;
    tick;
    chk("oor_ack_end", 32'(wr_ack),    32'd0);

    // Writer starved by continuous scan-out
    pix_req = 1'b1; pix_col = 10'd0; pix_row = 10'd0;
    wr_req = 1'b1; wr_addr = 15'd100; wr_data = 9'h007;
    for (int n = 1; n <= 300; n++) begin
      tick;
      chk("starve_noack",  32'(wr_ack),    32'd0);
      chk("starve_we",     32'(mem_we),    32'd0);
      chk("starve_flag",   32'(wr_starve), (n >= 255) ? 32'd1 : 32'd0);
    end
    pix_req = 1'b0;
    tick;
    chk("unstarve_ack",  32'(wr_ack),    32'd1);
    chk("unstarve_we",   32'(mem_we),    32'd1);
    chk("unstarve_addr", 32'(mem_addr),  32'd100);
    chk("unstarve_data", 32'(mem_wdata), 32'h007);
    chk("unstarve_flag", 32'(wr_starve), 32'd0);
    wr_req = 1'b0;
    tick;
    chk("unstarve_end",  32'(wr_ack),    32'd0);

    // Clear and writer in the same cycle: clear wins, writer waits for clr_done
    clr_start = 1'b1; clr_color = 9'h038;
    wr_req = 1'b1; wr_addr = 15'd50; wr_data = 9'h155;
    tick;
    chk("clr_start_busy", 32'(clr_busy), 32'd1);
    chk("clr_start_ack",  32'(wr_ack),   32'd0);
    chk("clr_start_we",   32'(mem_we),   32'd0);
    cnt = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 30000 && !done_seen; cyc++) begin
      pix_req   = (cyc % 7 == 3);
      clr_start = (cyc == 100);
      clr_color = (cyc == 100) ? 9'h1FF : 9'h038;
      tick;
      if (pix_req) chk("clr_stall_we", 32'(mem_we), 32'd0);
      if (mem_we) begin
        chk("clr_addr", 32'(mem_addr),  32'(cnt));
        chk("clr_data", 32'(mem_wdata), 32'h038);
        cnt++;
      end
      chk("clr_no_ack", 32'(wr_ack), 32'd0);
      if (clr_done) done_seen = 1'b1;
    end
    pix_req = 1'b0; clr_start = 1'b0;
    chk("clr_done_seen",  32'(done_seen), 32'd1);
    chk("clr_count",      32'(cnt),       32'd19200);
    chk("clr_busy_low",   32'(clr_busy),  32'd0);
    tick;
    chk("clr_done_pulse", 32'(clr_done),  32'd0);
    chk("post_clr_ack",   32'(wr_ack),    32'd1);
    chk("post_clr_addr",  32'(mem_addr),  32'd50);
    chk("post_clr_data",  32'(mem_wdata), 32'h155);
    wr_req = 1'b0;
    tick;

    // Reset in the middle of a clear, with a fetch in flight
    clr_start = 1'b1; clr_color = 9'h0C0;
    tick;
    clr_start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 6000 && !found; cyc++) begin
      tick;
      if (mem_we && mem_addr == 15'd5000) found = 1'b1;
    end
    chk("mid_clr_reached", 32'(found), 32'd1);
    pix_req = 1'b1;
    tick;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    pix_req = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick;
      chk("after_rst_valid", 32'(pix_valid), 32'd0);
      chk("after_rst_busy",  32'(clr_busy),  32'd0);
      chk("after_rst_done",  32'(clr_done),  32'd0);
      chk("after_rst_we",    32'(mem_we),    32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
